// File: rtl/mips16_control_fsm_if.sv
// Control-unit bundle: IR/ALU/memory inputs in, datapath selects and enables out.
// The master modport is the control FSM; the slave modport is the datapath side.
interface mips16_control_fsm_if;
    logic [15:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_sel;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic        bus_error;

    modport master (
        input  instr, zero, mem_ready,
        output alu_sel, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_we, pc_we,
               pc_src, reg_we, reg_dst, mem_to_reg, state, halted, illegal, bus_error
    );

    modport slave (
        output instr, zero, mem_ready,
        input  alu_sel, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_we, pc_we,
               pc_src, reg_we, reg_dst, mem_to_reg, state, halted, illegal, bus_error
    );
endinterface

// File: rtl/mips16_control_fsm.sv
// Multi-cycle MIPS16 main control: 3-5 cycles per instruction plus memory wait cycles;
// mem_req holds until mem_ready, and a stalled access past MEM_TIMEOUT cycles halts with bus_error.
module mips16_control_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    mips16_control_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        START  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        BRANCH = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_R0   = 4'h0;
    localparam logic [3:0] OP_R1   = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_J    = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t        cur, nxt;
    logic [3:0]    op_q;
    logic [2:0]    fn_q;
    logic          illegal_q, bus_error_q;
    logic [CW-1:0] wait_cnt;
    logic          to_hit, set_ill, set_berr;
    logic          r_type;

    logic unused_fields;
    assign unused_fields = ^bus.instr[11:3];

    function automatic logic is_illegal(input logic [3:0] op, input logic [2:0] fn);
        case (op)
            4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF: is_illegal = 1'b0;
            4'h1:    is_illegal = (fn == 3'd6) || (fn == 3'd7);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    assign r_type = (op_q == OP_R0) || (op_q == OP_R1);
    // mem_ready in the terminal wait cycle still completes the access
    assign to_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= START;
            op_q        <= '0;
            fn_q        <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= bus.instr[15:12];
                fn_q <= bus.instr[2:0];
            end
            if (set_ill)
                illegal_q <= 1'b1;
            if (set_berr)
                bus_error_q <= 1'b1;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (((cur == FETCH) || (cur == MEM)) && !bus.mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        nxt            = cur;
        set_ill        = 1'b0;
        set_berr       = 1'b0;
        bus.alu_sel    = ALU_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;
        case (cur)
            START: nxt = FETCH;
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    nxt       = DECODE;
                end else if (to_hit) begin
                    set_berr = 1'b1;
                    nxt      = HALT;
                end
            end
            DECODE: begin
                if (is_illegal(bus.instr[15:12], bus.instr[2:0])) begin
                    set_ill = 1'b1;
                    nxt     = HALT;
                end else begin
                    case (bus.instr[15:12])
                        OP_HALT:               nxt = HALT;
                        OP_BEQ, OP_BNE, OP_J:  nxt = BRANCH;
                        default:               nxt = EXEC;
                    endcase
                end
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                if (r_type) begin
                    bus.alu_sel   = {op_q[0], fn_q};
                    bus.alu_src_b = 2'b00;
                end else begin
                    bus.alu_src_b = 2'b10;
                end
                nxt = ((op_q == OP_LW) || (op_q == OP_SW)) ? MEM : WB;
            end
            MEM: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    nxt = (op_q == OP_SW) ? FETCH : WB;
                end else if (to_hit) begin
                    set_berr = 1'b1;
                    nxt      = HALT;
                end
            end
            WB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = r_type;
                bus.mem_to_reg = (op_q == OP_LW);
                nxt            = FETCH;
            end
            BRANCH: begin
                if (op_q == OP_J) begin
                    bus.pc_src = 2'b10;
                    bus.pc_we  = 1'b1;
                end else begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_sel   = (op_q == OP_BEQ) ? 4'b1110 : 4'b1111;
                    bus.pc_src    = 2'b01;
                    bus.pc_we     = bus.zero;
                end
                nxt = FETCH;
            end
            HALT:    bus.halted = 1'b1;
            default: nxt = START;
        endcase
    end

    assign bus.state     = cur;
    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;
endmodule

// File: tb/tb_mips16_control_fsm.sv
// Directed bench for mips16_control_fsm: expected output vectors are queued per cycle
// and compared mid-cycle against the full observed output set.
module tb_mips16_control_fsm;
    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_BRANCH = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       req;
        logic       we;
        logic       iord;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcs;
        logic       regwe;
        logic       dst;
        logic       m2r;
        logic       hlt;
        logic       ill;
        logic       berr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mips16_control_fsm_if bus();

    mips16_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    function automatic exp_t e_st(input logic [2:0] s);
        return exp_t'{st:s, default:0};
    endfunction

    function automatic exp_t e_fetch_ok();
        return exp_t'{st:S_FETCH, req:1'b1, sb:2'b01, irwe:1'b1, pcwe:1'b1, default:0};
    endfunction

    function automatic exp_t e_fetch_wait();
        return exp_t'{st:S_FETCH, req:1'b1, sb:2'b01, default:0};
    endfunction

    task automatic expect_now(input exp_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic chk();
        exp_t  e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {bus.state, bus.alu_sel, bus.alu_src_a, bus.alu_src_b, bus.mem_req, bus.mem_we,
             bus.iord, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we, bus.reg_dst,
             bus.mem_to_reg, bus.halted, bus.illegal, bus.bus_error};
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    task automatic cyc(input exp_t e, input string tag);
        expect_now(e, tag);
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [15:0] ins, input string tag);
        bus.instr = ins;
        bus.mem_ready = 1'b1;
        cyc(e_fetch_ok(), {tag, "_fetch"});
        cyc(e_st(S_DECODE), {tag, "_decode"});
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        expect_now(e_st(S_START), tag);
        chk();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(e_st(S_START), {tag, "_start"});
    endtask

    initial begin
        bus.instr = 16'h0000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(e_st(S_START), "in_reset");
        reset = 1'b0;
        cyc(e_st(S_START), "start");

        fetch_decode(16'h0A51, "sub");
        cyc(exp_t'{st:S_EXEC, alu:4'b0001, sa:1'b1, default:0}, "sub_exec");
        cyc(exp_t'{st:S_WB, regwe:1'b1, dst:1'b1, default:0}, "sub_wb");

        fetch_decode(16'h3A45, "lw");
        cyc(exp_t'{st:S_EXEC, sa:1'b1, sb:2'b10, default:0}, "lw_exec");
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(exp_t'{st:S_MEM, req:1'b1, iord:1'b1, default:0}, "lw_mem_wait");
        bus.mem_ready = 1'b1;
        cyc(exp_t'{st:S_MEM, req:1'b1, iord:1'b1, default:0}, "lw_mem_done");
        cyc(exp_t'{st:S_WB, regwe:1'b1, m2r:1'b1, default:0}, "lw_wb");

        fetch_decode(16'h4A45, "sw");
        cyc(exp_t'{st:S_EXEC, sa:1'b1, sb:2'b10, default:0}, "sw_exec");
        cyc(exp_t'{st:S_MEM, req:1'b1, we:1'b1, iord:1'b1, default:0}, "sw_mem");

        fetch_decode(16'h2A45, "addi");
        cyc(exp_t'{st:S_EXEC, sa:1'b1, sb:2'b10, default:0}, "addi_exec");
        cyc(exp_t'{st:S_WB, regwe:1'b1, default:0}, "addi_wb");

        fetch_decode(16'h1A45, "r1");
        cyc(exp_t'{st:S_EXEC, alu:4'b1101, sa:1'b1, default:0}, "r1_exec");
        cyc(exp_t'{st:S_WB, regwe:1'b1, dst:1'b1, default:0}, "r1_wb");

        bus.zero = 1'b1;
        fetch_decode(16'h5A42, "beq_t");
        cyc(exp_t'{st:S_BRANCH, alu:4'b1110, sa:1'b1, pcs:2'b01, pcwe:1'b1, default:0}, "beq_taken");
        bus.zero = 1'b0;
        fetch_decode(16'h5A42, "beq_n");
        cyc(exp_t'{st:S_BRANCH, alu:4'b1110, sa:1'b1, pcs:2'b01, default:0}, "beq_not");
        bus.zero = 1'b1;
        fetch_decode(16'h6A42, "bne_t");
        cyc(exp_t'{st:S_BRANCH, alu:4'b1111, sa:1'b1, pcs:2'b01, pcwe:1'b1, default:0}, "bne_taken");
        bus.zero = 1'b0;
        fetch_decode(16'h6A42, "bne_n");
        cyc(exp_t'{st:S_BRANCH, alu:4'b1111, sa:1'b1, pcs:2'b01, default:0}, "bne_not");
        fetch_decode(16'h7123, "j");
        cyc(exp_t'{st:S_BRANCH, pcs:2'b10, pcwe:1'b1, default:0}, "j_branch");

        fetch_decode(16'h4A45, "sw_rst");
        cyc(exp_t'{st:S_EXEC, sa:1'b1, sb:2'b10, default:0}, "sw_rst_exec");
        bus.mem_ready = 1'b0;
        cyc(exp_t'{st:S_MEM, req:1'b1, we:1'b1, iord:1'b1, default:0}, "sw_rst_mem");
        #2;
        do_reset("async_rst_mem");

        fetch_decode(16'h9000, "ill9");
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            bus.zero = i[1];
            cyc(exp_t'{st:S_HALT, hlt:1'b1, ill:1'b1, default:0}, "ill9_halt_hold");
        end
        do_reset("ill9_reset");

        fetch_decode(16'h1A46, "ill_fn6");
        cyc(exp_t'{st:S_HALT, hlt:1'b1, ill:1'b1, default:0}, "ill_fn6_halt");
        do_reset("ill_fn6_reset");

        fetch_decode(16'hF000, "halt_op");
        cyc(exp_t'{st:S_HALT, hlt:1'b1, default:0}, "halt_op_1");
        cyc(exp_t'{st:S_HALT, hlt:1'b1, default:0}, "halt_op_2");
        do_reset("halt_op_reset");

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc(e_fetch_wait(), "to_fetch_wait");
        cyc(exp_t'{st:S_HALT, hlt:1'b1, berr:1'b1, default:0}, "to_halt");
        cyc(exp_t'{st:S_HALT, hlt:1'b1, berr:1'b1, default:0}, "to_halt_hold");
        do_reset("to_reset");

        bus.instr = 16'h0A51;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(e_fetch_wait(), "late_fetch_wait");
        bus.mem_ready = 1'b1;
        cyc(e_fetch_ok(), "late_fetch_done");
        cyc(e_st(S_DECODE), "late_decode");
        cyc(exp_t'{st:S_EXEC, alu:4'b0001, sa:1'b1, default:0}, "late_exec");
        cyc(exp_t'{st:S_WB, regwe:1'b1, dst:1'b1, default:0}, "late_wb");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
